alu_div4: RTL and testbench
===========================

# alu_div4

Sequential 4-bit integer divider that sits beside the combinational 4-bit add/sub ALU and provides the inverse operation. It supports unsigned and two's-complement signed division with a restoring shift-and-subtract datapath, one quotient bit per clock. A start/busy/done handshake drives it, and it reports quotient, remainder and status flags (divide-by-zero, overflow, zero) to the same consumer that reads the ALU flags.

## Interface
- No parameters; the width is fixed at 4 bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request; sampled on the rising edge while in IDLE or DONE.
- Dividend  input  4  numerator; latched on an accepted Start.
- Divisor  input  4  denominator; latched on an accepted Start.
- Signed  input  1  0 = unsigned, 1 = two's-complement; latched on an accepted Start.
- Busy  output  1  high while an iteration is in progress.
- Done  output  1  one-cycle pulse when results become valid.
- Quotient  output  4  result; registered and held until the next accepted Start completes.
- Remainder  output  4  result; registered and held.
- DZ  output  1  divide-by-zero flag.
- OF  output  1  signed overflow flag (-8 / -1).
- ZF  output  1  Quotient == 0.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - If Start is 0, stay in IDLE.
  - If Start is 1, latch the operands and Signed. If the latched Divisor is 0, go to DONE. Otherwise go to CALC with the iteration counter set to 3.
- CALC:
  - Busy = 1.
  - Each cycle, shift {rem, dvd} left by 1 and trial-subtract the divisor magnitude from rem (5-bit compare).
  - If the subtraction does not borrow, keep the difference and set quotient bit 1. Otherwise restore rem and set quotient bit 0.
  - After the counter = 0 iteration, go to DONE.
- DONE: Done = 1 for exactly this cycle, and all outputs update this cycle.
  - If Start is 1, accept the new operation as in IDLE.
  - Otherwise go to IDLE.
- Signed mode:
  - The datapath operates on magnitudes. |-8| = 4'b1000, treated as unsigned 8.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the sign of the dividend (truncating division).
- Divide by zero: DZ = 1, Quotient = 4'b1111, Remainder = latched Dividend, OF = 0, ZF = 0. The CALC state is skipped.
- Signed overflow: a latched Dividend of 4'b1000 and Divisor of 4'b1111 give Quotient = 4'b1000 (wrapped), Remainder = 0, OF = 1.
- Flags are computed from the final sign-corrected values. ZF refers to Quotient only.
- Start while in CALC is ignored. Dividend, Divisor and Signed may change freely after acceptance without affecting the result.

## Timing
- Reset (rst_n = 0) is asynchronous and takes effect immediately, including mid-CALC. The partial operation is discarded.
  - State = IDLE.
  - Busy = 0, Done = 0.
  - Quotient = 0, Remainder = 0.
  - DZ = 0, OF = 0, ZF = 0. ZF resets to 0 even though Quotient = 0.
- Start accepted at edge N, normal divide:
  - Busy is high after edges N through N+3 (4 cycles).
  - Done is high and results are valid after edge N+4.
  - Latency is 5 edges from Start to Done.
- Start accepted at edge N, divide by zero: Done is high after edge N, Busy never rises, latency is 1.
- Back-to-back operation: holding Start high continuously yields one Done pulse every 5 cycles, with no idle gap.
- Outputs change only on the cycle Done rises. Between operations they hold their last values.

## Test plan
- Unsigned 13 / 3 (Dividend = 4'b1101, Divisor = 4'b0011, Signed = 0) -> Quotient = 4'b0100, Remainder = 4'b0001, DZ = OF = ZF = 0. Busy high for 4 cycles, then Done pulses once, 5 edges after Start.
- Signed -7 / 2 (4'b1001, 4'b0010, Signed = 1) -> Quotient = 4'b1101 (-3), Remainder = 4'b1111 (-1). Signed 7 / -2 -> Quotient = 4'b1101, Remainder = 4'b0001.
- Divide by zero, 5 / 0 -> Done 1 edge after Start, Busy stays 0, DZ = 1, Quotient = 4'b1111, Remainder = 4'b0101.
- Signed -8 / -1 -> Quotient = 4'b1000, Remainder = 0, OF = 1. Unsigned 2 / 9 -> Quotient = 0, Remainder = 4'b0010, ZF = 1.
- Handshake sequence:
  - Start 13 / 3, then during CALC pulse Start with 15 / 1 and change the operand inputs. Required: result is still 4 / 1 with a single Done.
  - Then hold Start high with 15 / 1. Required: 15 / 1 is accepted on the Done cycle, and the next Done follows exactly 5 cycles later.
- Assert rst_n = 0 during the second CALC cycle. Required: all outputs are 0 before the next clock edge and the state is IDLE. After release, 6 / 2 gives Quotient = 3, Remainder = 0 with normal latency.

Source files
------------

// File: rtl/alu_div4.sv
// rtl/alu_div4.sv - sequential 4-bit restoring divider, unsigned and signed
//
// Purpose:
//   Companion to the 4-bit add/sub ALU. Performs Dividend / Divisor with a
//   restoring shift-and-subtract datapath, one quotient bit per clock, and
//   reports quotient, remainder and DZ/OF/ZF flags.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start_i      request, sampled while idle or on the done cycle
//   dividend_i   numerator, latched on an accepted start
//   divisor_i    denominator, latched on an accepted start
//   signed_i     0 = unsigned, 1 = two's complement, latched on accept
//   busy_o       high while iterations are in progress
//   done_o       one-cycle pulse when results become valid
//   quotient_o   registered quotient, held until the next completion
//   remainder_o  registered remainder, held until the next completion
//   dz_o         divide-by-zero flag
//   of_o         signed overflow flag (-8 / -1)
//   zf_o         quotient is zero

module alu_div4 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic [3:0] dividend_i,
   input  logic [3:0] divisor_i,
   input  logic       signed_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [3:0] quotient_o,
   output logic [3:0] remainder_o,
   output logic       dz_o,
   output logic       of_o,
   output logic       zf_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] cnt_q,   cnt_d;
   logic [3:0] rem_q,   rem_d;    // partial remainder magnitude
   logic [3:0] dvd_q,   dvd_d;    // dividend magnitude, quotient bits shift in from the right
   logic [3:0] dsr_q,   dsr_d;    // divisor magnitude
   logic       qneg_q,  qneg_d;   // quotient must be negated at the end
   logic       rneg_q,  rneg_d;   // remainder must be negated at the end
   logic       ovf_q,   ovf_d;    // operands were -8 / -1 in signed mode

   logic [3:0] quo_q, quo_d;
   logic [3:0] rmd_q, rmd_d;
   logic       dz_q,  dz_d;
   logic       of_q,  of_d;
   logic       zf_q,  zf_d;

   logic [3:0] dvd_abs;
   logic [3:0] dsr_abs;
   logic [4:0] shifted;
   logic [5:0] trial;
   logic       borrow;
   logic [3:0] q_mag_nx;
   logic [3:0] r_mag_nx;
   logic [3:0] q_fin;
   logic [3:0] r_fin;

   // Magnitudes of the live inputs; |-8| wraps to 4'b1000, which the
   // datapath then treats as unsigned 8.
   assign dvd_abs = (signed_i && dividend_i[3]) ? (~dividend_i + 4'd1) : dividend_i;
   assign dsr_abs = (signed_i && divisor_i[3])  ? (~divisor_i  + 4'd1) : divisor_i;

   // One restoring step. The remainder is always below the divisor
   // magnitude (at most 8), so the shifted value fits in 5 bits and the
   // restored remainder fits back in 4.
   assign shifted  = {rem_q, dvd_q[3]};
   assign trial    = {1'b0, shifted} - {2'b00, dsr_q};
   assign borrow   = trial[5];
   assign q_mag_nx = {dvd_q[2:0], ~borrow};
   assign r_mag_nx = borrow ? shifted[3:0] : trial[3:0];

   // Sign correction of the last step's result. The -8 / -1 case needs no
   // special handling here: the magnitude 8 with no negation is already the
   // wrapped value 4'b1000.
   assign q_fin = qneg_q ? (~q_mag_nx + 4'd1) : q_mag_nx;
   assign r_fin = rneg_q ? (~r_mag_nx + 4'd1) : r_mag_nx;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      ovf_d   = ovf_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dz_d    = dz_q;
      of_d    = of_q;
      zf_d    = zf_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               cnt_d  = 2'd3;
               rem_d  = 4'd0;
               dvd_d  = dvd_abs;
               dsr_d  = dsr_abs;
               qneg_d = signed_i && (dividend_i[3] ^ divisor_i[3]);
               rneg_d = signed_i && dividend_i[3];
               ovf_d  = signed_i && (dividend_i == 4'b1000) && (divisor_i == 4'b1111);
               if (divisor_i == 4'd0) begin
                  // Division by zero completes on the accepting edge.
                  state_d = S_DONE;
                  quo_d   = 4'b1111;
                  rmd_d   = dividend_i;
                  dz_d    = 1'b1;
                  of_d    = 1'b0;
                  zf_d    = 1'b0;
               end else begin
                  state_d = S_CALC;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_CALC: begin
            rem_d = r_mag_nx;
            dvd_d = q_mag_nx;
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd0) begin
               state_d = S_DONE;
               quo_d   = q_fin;
               rmd_d   = r_fin;
               dz_d    = 1'b0;
               of_d    = ovf_q;
               zf_d    = (q_fin == 4'd0);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         rem_q   <= 4'd0;
         dvd_q   <= 4'd0;
         dsr_q   <= 4'd0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         ovf_q   <= 1'b0;
         quo_q   <= 4'd0;
         rmd_q   <= 4'd0;
         dz_q    <= 1'b0;
         of_q    <= 1'b0;
         zf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         ovf_q   <= ovf_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         dz_q    <= dz_d;
         of_q    <= of_d;
         zf_q    <= zf_d;
      end
   end

   assign busy_o      = (state_q == S_CALC);
   assign done_o      = (state_q == S_DONE);
   assign quotient_o  = quo_q;
   assign remainder_o = rmd_q;
   assign dz_o        = dz_q;
   assign of_o        = of_q;
   assign zf_o        = zf_q;

endmodule

// File: tb/tb_alu_div4.sv
// tb/tb_alu_div4.sv - self-checking bench for alu_div4

module tb_alu_div4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] dividend = 4'd0;
   logic [3:0] divisor = 4'd0;
   logic       sgn = 1'b0;
   logic       busy, done;
   logic [3:0] quotient, remainder;
   logic       dz, of, zf;

   int n_vec = 0;
   int n_bad = 0;

   alu_div4 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start),
      .dividend_i  (dividend),
      .divisor_i   (divisor),
      .signed_i    (sgn),
      .busy_o      (busy),
      .done_o      (done),
      .quotient_o  (quotient),
      .remainder_o (remainder),
      .dz_o        (dz),
      .of_o        (of),
      .zf_o        (zf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       s;
      logic [3:0] q;
      logic [3:0] r;
      logic       dz;
      logic       of;
      logic       zf;
      int         lat;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Truncating division with plain integer arithmetic.
   function automatic vec_t model(input logic [3:0] a, input logic [3:0] b, input logic s);
      vec_t v;
      int ia, ib, iq, ir;
      v.a = a; v.b = b; v.s = s;
      v.dz = 1'b0; v.of = 1'b0; v.zf = 1'b0;
      if (b == 4'd0) begin
         v.q = 4'b1111; v.r = a; v.dz = 1'b1; v.lat = 1;
      end else begin
         ia = int'(a);
         ib = int'(b);
         if (s && a[3]) ia = ia - 16;
         if (s && b[3]) ib = ib - 16;
         iq = ia / ib;
         ir = ia % ib;
         v.q = iq[3:0];
         v.r = ir[3:0];
         v.of = s && (ia == -8) && (ib == -1);
         v.zf = (v.q == 4'd0);
         v.lat = 5;
      end
      return v;
   endfunction

   // Issues one operation and waits for Done; on return the bench sits at
   // the falling edge where Done was seen (or the budget ran out).
   task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic s,
                        output int lat, output int nbusy);
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b; sgn = s;
      @(negedge clk);
      start = 1'b0;
      dividend = 4'($urandom);
      divisor = 4'($urandom);
      sgn = 1'($urandom);
      lat = 1;
      nbusy = 0;
      while (!done && lat < 12) begin
         if (busy) nbusy++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic check_op(input string tag, input vec_t e);
      int lat, nbusy;
      do_op(e.a, e.b, e.s, lat, nbusy);
      check({tag, " latency"}, lat, e.lat);
      check({tag, " busy cycles"}, nbusy, (e.lat == 5) ? 4 : 0);
      check({tag, " quotient"}, quotient, e.q);
      check({tag, " remainder"}, remainder, e.r);
      check({tag, " flags dz/of/zf"}, {dz, of, zf}, {e.dz, e.of, e.zf});
   endtask

   initial begin
      int ndone;

      tbl[0] = '{4'd13,    4'd3,    1'b0, 4'b0100, 4'b0001, 1'b0, 1'b0, 1'b0, 5};
      tbl[1] = '{4'b1001,  4'b0010, 1'b1, 4'b1101, 4'b1111, 1'b0, 1'b0, 1'b0, 5};
      tbl[2] = '{4'b0111,  4'b1110, 1'b1, 4'b1101, 4'b0001, 1'b0, 1'b0, 1'b0, 5};
      tbl[3] = '{4'd5,     4'd0,    1'b0, 4'b1111, 4'b0101, 1'b1, 1'b0, 1'b0, 1};
      tbl[4] = '{4'b1000,  4'b1111, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 5};
      tbl[5] = '{4'd2,     4'd9,    1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b1, 5};
      tbl[6] = '{4'd15,    4'd1,    1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 5};
      tbl[7] = '{4'b1000,  4'd0,    1'b1, 4'b1111, 4'b1000, 1'b1, 1'b0, 1'b0, 1};
      tbl[8] = '{4'd0,     4'd5,    1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 5};
      tbl[9] = '{4'b1111,  4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 5};

      // Reset state
      #1;
      check("reset outputs", {busy, done, quotient, remainder, dz, of, zf}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 10; i++) begin
         check_op($sformatf("tbl[%0d]", i), tbl[i]);
      end

      // Start during CALC is ignored, then Start held across Done cycles.
      @(negedge clk);
      start = 1'b1; dividend = 4'd13; divisor = 4'd3; sgn = 1'b0;
      ndone = 0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         check($sformatf("handshake done at cycle %0d", i), done, (i % 5 == 0));
         if (done) ndone++;
         if (i == 1) start = 1'b0;
         if (i == 2) begin start = 1'b1; dividend = 4'd15; divisor = 4'd1; end
         if (i == 3) begin start = 1'b0; dividend = 4'd7; divisor = 4'd0; sgn = 1'b1; end
         if (i == 5) begin
            check("handshake 13/3", {quotient, remainder}, {4'd4, 4'd1});
            start = 1'b1; dividend = 4'd15; divisor = 4'd1; sgn = 1'b0;
         end
         if (i == 10) check("back-to-back 15/1 first", {quotient, remainder}, {4'd15, 4'd0});
         if (i == 15) begin
            check("back-to-back 15/1 second", {quotient, remainder}, {4'd15, 4'd0});
            start = 1'b0;
         end
      end
      check("handshake done count", ndone, 3);

      // Asynchronous reset in the second CALC cycle
      @(negedge clk);
      start = 1'b1; dividend = 4'd13; divisor = 4'd3; sgn = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid-calc reset outputs", {busy, done, quotient, remainder, dz, of, zf}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      check_op("after reset 6/2", model(4'd6, 4'd2, 1'b0));

      // Randomised operations against the reference model
      for (int i = 0; i < 150; i++) begin
         logic [3:0] ra, rb;
         logic       rs;
         ra = 4'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
         rs = 1'($urandom);
         check_op($sformatf("rand %0d (%0d/%0d s%0d)", i, ra, rb, rs), model(ra, rb, rs));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
